// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard front end: frame states,
// prefix codes and the list of keyboard status bytes that never become events.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_t;

    // Layout of the 11-bit toggle-event word seen by the core's decoder.
    typedef struct packed {
        logic       toggle;
        logic       pressed;
        logic       ext;
        logic [7:0] code;
    } ps2_key_t;

    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_BRK        = 8'hF0;
    localparam logic [7:0] PS2_PAUSE      = 8'hE1;
    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

    // Self-test, echo, ack, resend and error replies from the keyboard.
    localparam int PS2_NUM_DROP = 8;
    localparam logic [PS2_NUM_DROP-1:0][7:0] PS2_DROP_CODES = {
        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF
    };

    function automatic logic ps2_is_dropped(input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < PS2_NUM_DROP; i++)
            if (PS2_DROP_CODES[i] == code) hit = 1'b1;
        return hit;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter for one raw
// PS/2 pin; the output only follows a level held for FILTER_LEN samples.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic line_in,
    output logic line_out
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync;
    logic [CW-1:0] run_cnt;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            sync     <= 2'b11;
            line_out <= 1'b1;
            run_cnt  <= '0;
        end else begin
            sync <= {sync[0], line_in};
            // Any sample agreeing with the current output restarts the run.
            if (sync[1] == line_out) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
                line_out <= sync[1];
                run_cnt  <= '0;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 device-to-host deserializer and scan-code folder producing the
// toggle-event word ps2_key consumed by the core's keyboard decoder.
module ps2_key_encoder
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 24_000_000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 2000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk_in,
    input  logic        ps2_dat_in,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam int TO_LIMIT = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);

    logic clk_f, dat_f, clk_prev, strobe;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .line_in  (ps2_clk_in),
        .line_out (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .line_in  (ps2_dat_in),
        .line_out (dat_f)
    );

    assign strobe = clk_prev & ~clk_f;

    ps2_state_t      state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            par_bit;
    logic [TO_W-1:0] to_cnt;
    logic            byte_vld;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            clk_prev  <= 1'b1;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            to_cnt    <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            clk_prev  <= clk_f;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;

            if (state == ST_IDLE || strobe) to_cnt <= '0;
            else                            to_cnt <= to_cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (strobe && !dat_f) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (strobe) begin
                        shreg   <= {dat_f, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    if (strobe) begin
                        par_bit <= dat_f;
                        state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (strobe) begin
                        if (dat_f && ^{par_bit, shreg}) byte_vld  <= 1'b1;
                        else                            frame_err <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A strobe landing on the expiry cycle keeps the frame alive.
            if (!strobe && state != ST_IDLE && to_cnt == TO_W'(TO_LIMIT)) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
            end
        end
    end

    // shreg is stable in IDLE, so the decoder reads it directly on byte_vld.
    ps2_key_t   key;
    logic       ext, brk;
    logic [2:0] skip;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            key  <= '0;
            ext  <= 1'b0;
            brk  <= 1'b0;
            skip <= '0;
        end else if (frame_err) begin
            ext  <= 1'b0;
            brk  <= 1'b0;
            skip <= '0;
        end else if (byte_vld) begin
            if (shreg == PS2_PAUSE) begin
                skip <= PS2_PAUSE_SKIP;
            end else if (skip != 3'd0) begin
                skip <= skip - 1'b1;
            end else if (shreg == PS2_EXT) begin
                ext <= 1'b1;
            end else if (shreg == PS2_BRK) begin
                brk <= 1'b1;
            end else begin
                if (!ps2_is_dropped(shreg)) begin
                    key.toggle  <= ~key.toggle;
                    key.pressed <= ~brk;
                    key.ext     <= ext;
                    key.code    <= shreg;
                end
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

    assign ps2_key = key;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Drives PS/2 frames (directed plus randomized) into ps2_key_encoder and
// compares ps2_key, error pulses and event counts with a scan-code model.
module tb_ps2_key_encoder;

    localparam int HALF = 20;   // half PS/2 bit period in clk_sys cycles

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;

    ps2_key_encoder #(
        .CLK_HZ     (2_000_000),
        .FILTER_LEN (8),
        .TIMEOUT_US (100)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_clk_in (ps2_clk),
        .ps2_dat_in (ps2_dat),
        .ps2_key    (ps2_key),
        .frame_err  (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    // Observed activity, counted only while out of reset.
    int   err_cnt  = 0;
    int   wide_cnt = 0;
    int   tog_cnt  = 0;
    logic err_prev = 1'b0;
    logic tog_prev = 1'b0;

    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (frame_err)             err_cnt  <= err_cnt + 1;
            if (frame_err && err_prev) wide_cnt <= wide_cnt + 1;
            if (ps2_key[10] != tog_prev) tog_cnt <= tog_cnt + 1;
        end
        err_prev <= frame_err;
        tog_prev <= ps2_key[10];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Behavioural model of the scan-code folding.
    logic [10:0] m_key  = '0;
    logic        m_ext  = 1'b0;
    logic        m_brk  = 1'b0;
    int          m_skip = 0;
    int          m_errs = 0;
    int          m_togs = 0;

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE1) m_skip = 7;
        else if (m_skip > 0) m_skip--;
        else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF}) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            m_key = {~m_key[10], ~m_brk, m_ext, b};
            m_togs++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_err();
        m_errs++;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_skip = 0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_sys);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            wait_cyc(HALF / 2);
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
            wait_cyc(HALF / 2);
        end
        ps2_dat = 1'b1;
    endtask

    task automatic check_all(input string tag);
        @(negedge clk_sys);
        chk({tag, "_key"}, 32'(ps2_key), 32'(m_key));
        chk({tag, "_errs"}, 32'(err_cnt), 32'(m_errs));
        chk({tag, "_togs"}, 32'(tog_cnt), 32'(m_togs));
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~^b ^ bad_par;
        send_bits({~bad_stop, par, b, 1'b0}, 11);
        wait_cyc(2 * HALF);
        if (bad_par || bad_stop) model_err();
        else                     model_byte(b);
    endtask

    task automatic send_seq(input logic [7:0] b[$], input string tag);
        foreach (b[i]) send_frame(b[i], 1'b0, 1'b0);
        check_all(tag);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: run did not finish, want finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] r;
        int         sel;
        bit         bp, bs;

        wait_cyc(5);
        @(negedge clk_sys);
        chk("rst_key", 32'(ps2_key), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        reset_n = 1'b1;
        wait_cyc(30);

        send_seq('{8'h1C}, "make_1c");
        chk("make_1c_word", 32'(ps2_key), 32'h61C);
        send_seq('{8'hF0, 8'h1C}, "brk_1c");
        chk("brk_1c_low", 32'(ps2_key[9:0]), 32'h01C);
        send_seq('{8'hE0, 8'hF0, 8'h75}, "ext_brk_75");
        send_seq('{8'hE0, 8'h75}, "ext_75");

        send_frame(8'h29, 1'b1, 1'b0);
        check_all("bad_par_29");
        send_seq('{8'h29}, "good_29");
        send_frame(8'h29, 1'b0, 1'b1);
        check_all("bad_stop_29");

        // Four clocks of a frame, then silence past the timeout.
        send_bits({1'b1, 1'b0, 8'h16, 1'b0}, 4);
        wait_cyc(300);
        model_err();
        check_all("timeout");
        send_seq('{8'h16}, "after_to_16");

        // Short clock dip with data low must not start a frame.
        ps2_dat = 1'b0;
        wait_cyc(20);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(20);
        ps2_dat = 1'b1;
        wait_cyc(30);
        check_all("glitch");
        send_seq('{8'h1C}, "after_glitch");

        // The second E1 reloads the skip window, so trailing bytes are eaten too.
        send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77}, "pause");
        send_seq('{8'h1C, 8'h1C, 8'h1C, 8'h1C}, "after_pause");

        for (int n = 0; n < 30; n++) begin
            sel = int'($urandom_range(0, 11));
            case (sel)
                0:       r = 8'hE0;
                1, 2:    r = 8'hF0;
                3:       r = 8'hAA;
                4:       r = 8'hFA;
                5:       r = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h5A;
                default: r = 8'($urandom);
            endcase
            sel = int'($urandom_range(0, 9));
            bp  = (sel == 0);
            bs  = (sel == 1);
            send_frame(r, bp, bs);
            check_all($sformatf("rand%0d", n));
        end

        // Reset in the middle of a frame: no event, no error.
        send_bits({1'b1, 1'b0, 8'h3B, 1'b0}, 5);
        wait_cyc(20);
        reset_n = 1'b0;
        wait_cyc(5);
        reset_n = 1'b1;
        m_key  = '0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_skip = 0;
        wait_cyc(30);
        check_all("mid_reset");
        send_seq('{8'h1C}, "after_reset");

        @(negedge clk_sys);
        chk("ferr_width", 32'(wide_cnt), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
